dctq_zigzag_reader: RTL
=======================

Name: dctq_zigzag_reader

Overview:
- Consumer side of the DCTQ result interface: on each `dctq_valid` block announcement, reads the 64 quantized coefficients out of the DCTQ result memory.
- Reads are issued through `rd_addr`/`rd_en`, in zigzag order.
- Streams the coefficients to the entropy-coding stage over a valid/ready handshake, marking the 64th with `coef_last`.
- Sits between the DCTQ result buffer and the run-length/Huffman encoder; honours the same global `hold` freeze as the DCTQ controller.

Parameters:
- COEF_W, 12, coefficient width in bits (memory read data and output data)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- hold  input  1  global freeze; blocks start detection and new read issue
- dctq_valid  input  1  block-ready indication from DCTQ controller; rising edge announces a block
- rd_en  output  1  result-memory read strobe
- rd_addr  output  6  result-memory read address
- rd_data  input  COEF_W  result-memory read data, valid exactly 1 cycle after rd_en
- coef_out  output  COEF_W  coefficient to encoder
- coef_valid  output  1  coef_out valid
- coef_ready  input  1  encoder accepts coef_out when coef_valid & coef_ready
- coef_last  output  1  high with the 64th coefficient of a block
- busy  output  1  high from block start until last coefficient accepted
- overrun  output  1  sticky: block announced while one was already pending

Behaviour:
- Reset values: rd_en=0, rd_addr=0, coef_out=0, coef_valid=0, coef_last=0, busy=0, overrun=0; FIFO empty; index=0; pending=0; dctq_valid edge register=0.
- Edge detect:
  - `dctq_valid` is registered every cycle that `hold`=0 (frozen when `hold`=1).
  - A start event is `dctq_valid`=1 with registered value 0, with `hold`=0.
- State machine: IDLE, READ, DRAIN.
  - IDLE: start event or pending=1 -> READ; clear pending; index=0; busy=1.
  - READ: issue a read each cycle where `hold`=0 and (FIFO count + reads in flight) < 2.
    - rd_addr = zz(index); index increments per read.
    - After the read with index 63 -> DRAIN.
  - DRAIN: when the 64th coefficient is accepted -> IDLE; busy=0 in the following cycle.
    - If pending=1 at that point, go straight to READ instead, with busy staying 1.
- Start event while busy: set pending. Start event while pending is already 1: set overrun, event dropped.
- Start event in the same cycle that DRAIN completes: it becomes pending and is serviced immediately.
- Read timing: rd_en in cycle c -> rd_data sampled into the 2-entry FIFO at the end of c+1 -> coef_valid earliest in c+2.
  - First coef_valid therefore appears 3 cycles after the start-event cycle.
- FIFO: 2 entries; coef_out/coef_valid driven from the FIFO head.
  - Pop on coef_valid & coef_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - The in-flight accounting guarantees the FIFO never overflows.
- Throughput: with coef_ready held at 1 and `hold`=0, one coefficient per cycle, 64 consecutive cycles.
- Backpressure:
  - coef_ready=0 holds coef_out/coef_valid/coef_last stable.
  - At most 2 coefficients are buffered; reads stall.
- coef_last: a tag bit stored with each FIFO entry, set for index 63.
- hold=1:
  - No new reads and no state transitions.
  - A read already issued is still captured.
  - The output handshake keeps running.
- Address width: index is a 6-bit counter, reset to 0 at each block start; no wrap beyond 63 within a block.
- Asynchronous reset mid-block: the block is abandoned; all state and outputs return to their reset values; no partial block resumes.

Optional Feature:
- Macro `DCTQ_ZIGZAG_EN`.
  - Defined: zz(i) is the JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,... ending 47,55,62,63), implemented as a 64-entry constant case.
  - Undefined: zz(i)=i (raster order); no table is synthesized.
- Handshake, latency and coef_last position are identical in both builds.

Test Plan:
- Reset then idle: reset_n low 3 cycles, `dctq_valid`=0 -> all outputs 0, no rd_en for 20 cycles.
- Single block, coef_ready=1, memory word[a]=a:
  - First coef_valid 3 cycles after the `dctq_valid` rise, then 64 consecutive beats.
  - With `DCTQ_ZIGZAG_EN`, beats 0..5 = 0,1,8,16,9,2 and beat 63 = 63 with coef_last=1.
  - Without the macro, beat n = n.
- Backpressure: coef_ready toggles 1/0 each cycle -> 64 beats over ~128 cycles, no loss or duplication, coef_out stable while stalled, rd_en stalls with ≤2 buffered.
- Hold: `hold`=1 for 10 cycles at beat 20 -> no rd_en during hold, buffered beats still drain, sequence resumes at the correct address, 64 beats total.
- Back-to-back and overrun:
  - Second `dctq_valid` rise mid-block -> second block starts with no idle cycle; busy stays 1.
  - Third rise before the second starts -> overrun=1, and it stays 1 until reset.
- Reset mid-block at beat 30 -> outputs return to reset values immediately; the next `dctq_valid` rise produces a full 64-beat block starting at address 0.

Source files
------------

// File: rtl/dctq_zigzag_reader.sv
// Reads a 64-coefficient block from the DCTQ result memory and streams it to the encoder.
// Define DCTQ_ZIGZAG_EN to read in JPEG zigzag order; otherwise raster order is used.
module dctq_zigzag_reader #(
  parameter int unsigned COEF_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              dctq_valid,
  output logic              rd_en,
  output logic [5:0]        rd_addr,
  input  logic [COEF_W-1:0] rd_data,
  output logic [COEF_W-1:0] coef_out,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              coef_last,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  function automatic logic [5:0] zz(input logic [5:0] i);
`ifdef DCTQ_ZIGZAG_EN
    zz = 6'd0;
    case (i)
      6'd0:  zz = 6'd0;  6'd1:  zz = 6'd1;  6'd2:  zz = 6'd8;  6'd3:  zz = 6'd16;
      6'd4:  zz = 6'd9;  6'd5:  zz = 6'd2;  6'd6:  zz = 6'd3;  6'd7:  zz = 6'd10;
      6'd8:  zz = 6'd17; 6'd9:  zz = 6'd24; 6'd10: zz = 6'd32; 6'd11: zz = 6'd25;
      6'd12: zz = 6'd18; 6'd13: zz = 6'd11; 6'd14: zz = 6'd4;  6'd15: zz = 6'd5;
      6'd16: zz = 6'd12; 6'd17: zz = 6'd19; 6'd18: zz = 6'd26; 6'd19: zz = 6'd33;
      6'd20: zz = 6'd40; 6'd21: zz = 6'd48; 6'd22: zz = 6'd41; 6'd23: zz = 6'd34;
      6'd24: zz = 6'd27; 6'd25: zz = 6'd20; 6'd26: zz = 6'd13; 6'd27: zz = 6'd6;
      6'd28: zz = 6'd7;  6'd29: zz = 6'd14; 6'd30: zz = 6'd21; 6'd31: zz = 6'd28;
      6'd32: zz = 6'd35; 6'd33: zz = 6'd42; 6'd34: zz = 6'd49; 6'd35: zz = 6'd56;
      6'd36: zz = 6'd57; 6'd37: zz = 6'd50; 6'd38: zz = 6'd43; 6'd39: zz = 6'd36;
      6'd40: zz = 6'd29; 6'd41: zz = 6'd22; 6'd42: zz = 6'd15; 6'd43: zz = 6'd23;
      6'd44: zz = 6'd30; 6'd45: zz = 6'd37; 6'd46: zz = 6'd44; 6'd47: zz = 6'd51;
      6'd48: zz = 6'd58; 6'd49: zz = 6'd59; 6'd50: zz = 6'd52; 6'd51: zz = 6'd45;
      6'd52: zz = 6'd38; 6'd53: zz = 6'd31; 6'd54: zz = 6'd39; 6'd55: zz = 6'd46;
      6'd56: zz = 6'd53; 6'd57: zz = 6'd60; 6'd58: zz = 6'd61; 6'd59: zz = 6'd54;
      6'd60: zz = 6'd47; 6'd61: zz = 6'd55; 6'd62: zz = 6'd62; 6'd63: zz = 6'd63;
    endcase
`else
    zz = i;
`endif
  endfunction

  state_t            state_q, state_d;
  logic              dv_q, dv_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              done_q, done_d;
  logic [5:0]        index_q, index_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [COEF_W-1:0] fifo_data_q [2];
  logic [COEF_W-1:0] fifo_data_d [2];
  logic              fifo_last_q [2];
  logic              fifo_last_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic       start;
  logic       pop;
  logic       last_pop;
  logic [2:0] occ_after;

  assign coef_valid = (count_q != 2'd0);
  assign pop        = coef_valid & coef_ready;
  assign last_pop   = pop & fifo_last_q[rd_ptr_q];
  assign coef_out   = coef_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign coef_last  = coef_valid & fifo_last_q[rd_ptr_q];
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;
  assign rd_addr    = zz(index_q);
  assign start      = dctq_valid & ~dv_q & ~hold;
  // Occupancy after this cycle's pop: buffered entries plus the read landing next cycle.
  assign occ_after  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    done_d    = done_q;
    index_d   = index_q;
    dv_d      = hold ? dv_q : dctq_valid;
    rd_en     = (state_q == ST_READ) && !hold && (occ_after < 3'd2);

    if (start && (state_q != ST_IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!hold && (start || pending_q)) begin
          state_d   = ST_READ;
          index_d   = 6'd0;
          pending_d = start & pending_q;
        end
      end
      ST_READ: begin
        if (rd_en) begin
          index_d = index_q + 6'd1;
          if (index_q == 6'd63) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A last beat accepted under hold is remembered until the freeze lifts.
        if (!hold && (last_pop || done_q)) begin
          done_d = 1'b0;
          if (pending_q || start) begin
            state_d   = ST_READ;
            index_d   = 6'd0;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (last_pop) begin
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en && (index_q == 6'd63);
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = rd_data;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      dv_q            <= 1'b0;
      pending_q       <= 1'b0;
      overrun_q       <= 1'b0;
      done_q          <= 1'b0;
      index_q         <= 6'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      for (int k = 0; k < 2; k++) begin
        fifo_data_q[k] <= '0;
        fifo_last_q[k] <= 1'b0;
      end
    end else begin
      state_q         <= state_d;
      dv_q            <= dv_d;
      pending_q       <= pending_d;
      overrun_q       <= overrun_d;
      done_q          <= done_d;
      index_q         <= index_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      for (int k = 0; k < 2; k++) begin
        fifo_data_q[k] <= fifo_data_d[k];
        fifo_last_q[k] <= fifo_last_d[k];
      end
    end
  end

endmodule
